timer_counter: RTL and testbench

TIMER_COUNTER -- requirements
Module: timer_counter

---
 rtl/timer_counter.sv | 108 ++++++++++
 tb/tb_timer_counter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer: CTRL / PRESET / COUNT registers, a
// four-state load/count/interrupt FSM, and a maskable level interrupt.
module timer_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:2] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StLoad = 2'b01,
        StCnt  = 2'b10,
        StInt  = 2'b11
    } state_e;

    localparam logic [1:0] AddrCtrl   = 2'b00;
    localparam logic [1:0] AddrPreset = 2'b01;
    localparam logic [1:0] AddrCount  = 2'b10;

    state_e      state_q;
    logic [3:0]  ctrl_q;
    logic [31:0] preset_q;
    logic [31:0] count_q;
    logic        irq_flag_q;

    logic        enable;
    logic        auto_reload;
    logic        ctrl_wr;
    logic        preset_wr;

    assign enable      = ctrl_q[0];
    // Only Mode=01 reloads; 10 and 11 fall back to one-shot.
    assign auto_reload = (ctrl_q[2:1] == 2'b01);
    assign ctrl_wr     = WE && (Addr[3:2] == AddrCtrl);
    assign preset_wr   = WE && (Addr[3:2] == AddrPreset);

    // Register file, FSM and interrupt flag; bus writes are applied after the
    // FSM so a CPU CTRL write overrides the FSM clearing Enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            ctrl_q     <= 4'h0;
            preset_q   <= 32'h0;
            count_q    <= 32'h0;
            irq_flag_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (enable) begin
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    count_q    <= preset_q;
                    irq_flag_q <= 1'b0;
                    state_q    <= StCnt;
                end
                StCnt: begin
                    if (!enable) begin
                        state_q <= StIdle;
                    end else if (count_q > 32'd1) begin
                        count_q <= count_q - 32'd1;
                    end else begin
                        // Covers COUNT of 1 and of 0 (PRESET=0), so no wrap.
                        count_q    <= 32'h0;
                        irq_flag_q <= 1'b1;
                        state_q    <= StInt;
                    end
                end
                StInt: begin
                    if (auto_reload) begin
                        irq_flag_q <= 1'b0;
                    end else begin
                        ctrl_q[0] <= 1'b0;
                    end
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase

            if (ctrl_wr) begin
                ctrl_q     <= Din[3:0];
                irq_flag_q <= 1'b0;
            end
            if (preset_wr) begin
                preset_q <= Din;
            end
        end
    end

    // Combinational read mux.
    always_comb begin
        Dout = 32'h0;
        unique case (Addr[3:2])
            AddrCtrl:   Dout = {28'h0, ctrl_q};
            AddrPreset: Dout = preset_q;
            AddrCount:  Dout = count_q;
            default:    Dout = 32'h0;
        endcase
    end

    assign IRQ = irq_flag_q & ctrl_q[3];

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: expected read/IRQ values are queued as each
// check is issued and popped for comparison once the DUT output has settled.
module tb_timer_counter;

    logic        clk;
    logic        reset;
    logic [31:2] addr;
    logic        we;
    logic [31:0] din;
    logic [31:0] dout;
    logic        irq;

    typedef struct {
        string       tag;
        logic [31:0] dout;
        logic        irq;
    } exp_t;

    exp_t sb_q[$];
    int   vectors;
    int   miscompares;

    timer_counter dut (
        .clk  (clk),
        .reset(reset),
        .Addr (addr),
        .WE   (we),
        .Din  (din),
        .Dout (dout),
        .IRQ  (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; returns 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Bus write sampled at the next rising edge.
    task automatic wr(input logic [31:0] byte_addr, input logic [31:0] data);
        addr = byte_addr[31:2];
        din  = data;
        we   = 1'b1;
        tick();
        we   = 1'b0;
        din  = 32'h0;
    endtask

    // Queue the expectation, select the register, then pop and compare.
    task automatic check(input string tag, input logic [31:0] byte_addr,
                         input logic [31:0] exp_dout, input logic exp_irq);
        exp_t e;
        e.tag  = tag;
        e.dout = exp_dout;
        e.irq  = exp_irq;
        sb_q.push_back(e);
        addr = byte_addr[31:2];
        #1;
        e = sb_q.pop_front();
        vectors++;
        assert (dout === e.dout && irq === e.irq)
        else begin
            miscompares++;
            $error("FAIL %s: observed Dout=%h IRQ=%b, expected Dout=%h IRQ=%b",
                   e.tag, dout, irq, e.dout, e.irq);
        end
    endtask

    initial begin
        logic [31:0] exp_cnt;
        logic        exp_irq;
        int          p;

        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        addr        = '0;
        we          = 1'b0;
        din         = 32'h0;

        // Reset overrides a concurrent PRESET write.
        addr = 30'h1;
        din  = 32'hFFFF_FFFF;
        we   = 1'b1;
        ticks(2);
        we    = 1'b0;
        reset = 1'b0;
        check("rst_ctrl",   32'h0, 32'h0, 1'b0);
        check("rst_preset", 32'h4, 32'h0, 1'b0);
        check("rst_count",  32'h8, 32'h0, 1'b0);
        check("rst_rsvd",   32'hC, 32'h0, 1'b0);

        // One-shot, PRESET=5, IM=1.
        wr(32'h4, 32'd5);
        check("preset_rd", 32'h4, 32'd5, 1'b0);
        wr(32'h0, 32'h9);                         // edge N
        check("os_ctrl_rd", 32'h0, 32'h9, 1'b0);
        for (int i = 1; i <= 7; i++) begin
            tick();                               // edge N+i
            exp_cnt = (i < 2) ? 32'd0 : (i == 7) ? 32'd0 : 32'(7 - i);
            check($sformatf("os_cnt_%0d", i), 32'h8, exp_cnt, i == 7);
        end
        tick();                                   // INT -> IDLE clears Enable
        check("os_ctrl_after", 32'h0, 32'h8, 1'b1);
        ticks(3);
        check("os_irq_hold", 32'h8, 32'h0, 1'b1);
        wr(32'h0, 32'h8);
        check("os_irq_clr", 32'h8, 32'h0, 1'b0);

        // Auto-reload, PRESET=3: 1-cycle IRQ every 6 cycles.
        wr(32'h4, 32'd3);
        wr(32'h0, 32'hB);                         // edge N
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i < 2) begin
                exp_cnt = 32'd0;
                exp_irq = 1'b0;
            end else begin
                p       = (i - 2) % 6;
                exp_cnt = (p < 3) ? 32'(3 - p) : 32'd0;
                exp_irq = (p == 3);
            end
            check($sformatf("ar_%0d", i), 32'h8, exp_cnt, exp_irq);
        end

        // Disable mid-count, IM=0.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        wr(32'h4, 32'd100);
        wr(32'h0, 32'h1);                         // edge N
        ticks(61);
        wr(32'h0, 32'h0);                         // edge N+62: COUNT=40
        check("dis_cnt40", 32'h8, 32'd40, 1'b0);
        tick();
        check("dis_hold1", 32'h8, 32'd40, 1'b0);
        ticks(10);
        check("dis_hold2", 32'h8, 32'd40, 1'b0);
        wr(32'h0, 32'h1);                         // edge M
        tick();
        check("dis_load_pending", 32'h8, 32'd40, 1'b0);
        tick();
        check("dis_reload", 32'h8, 32'd100, 1'b0);
        // PRESET write during count leaves COUNT alone.
        wr(32'h4, 32'd7);
        check("preset_mid", 32'h8, 32'd99, 1'b0);

        // PRESET=0 behaves as 1; COUNT writes ignored.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        wr(32'h0, 32'h9);                         // edge N
        tick();
        tick();
        check("p0_n2", 32'h8, 32'd0, 1'b0);
        tick();
        check("p0_n3", 32'h8, 32'd0, 1'b1);
        wr(32'h8, 32'h8);
        check("p0_cnt_wr", 32'h8, 32'd0, 1'b1);
        wr(32'hC, 32'hFFFF_FFFF);
        check("p0_rsvd_wr", 32'hC, 32'd0, 1'b1);
        check("p0_ctrl", 32'h0, 32'h8, 1'b1);

        // CTRL write colliding with one-shot INT: CPU value kept, flag cleared.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        wr(32'h4, 32'd1);
        wr(32'h0, 32'h9);                         // edge N
        ticks(3);                                 // edge N+3: INT entered
        check("col_irq", 32'h8, 32'd0, 1'b1);
        wr(32'h0, 32'h9);                         // edge N+4, state INT
        check("col_ctrl", 32'h0, 32'h9, 1'b0);
        tick();
        tick();
        check("col_reload", 32'h8, 32'd1, 1'b0);
        tick();
        check("col_irq2", 32'h8, 32'd0, 1'b1);

        // Reset mid-count.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        wr(32'h4, 32'd20);
        wr(32'h0, 32'h9);                         // edge N
        ticks(15);
        check("mid_cnt7", 32'h8, 32'd7, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_ctrl",   32'h0, 32'h0, 1'b0);
        check("mid_preset", 32'h4, 32'h0, 1'b0);
        check("mid_count",  32'h8, 32'h0, 1'b0);
        ticks(6);
        check("mid_noreload", 32'h8, 32'h0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
